booth_seq_mul: RTL and testbench

//   Sequential radix-2 Booth multiplier, the inverse operator of the team's combinational
//   non-restoring divider: rebuilds N = Q*D (+R added by the caller) for divider self-check.
//   One Booth iteration per clock, with a start/done handshake. Sits beside the divider
//   in the arithmetic datapath.

---
 rtl/divmul_pkg.sv | 18 +
 rtl/booth_step.sv | 33 +++
 rtl/booth_seq_mul.sv | 93 +++++++++
 tb/tb_booth_seq_mul.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/divmul_pkg.sv
// Shared types for the divider/multiplier datapath.
// Holds the sequencer state encoding and a clog2 helper.
package divmul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: add/sub then arithmetic shift.
// Ports: a/qr/q_1/mr current state in, a_nx/qr_nx/q_1_nx next state out.
module booth_step
   import divmul_pkg::*;
#(
   parameter int E = 5
) (
   input  logic [E-1:0] a,
   input  logic [E-1:0] qr,
   input  logic         q_1,
   input  logic [E-1:0] mr,
   output logic [E-1:0] a_nx,
   output logic [E-1:0] qr_nx,
   output logic         q_1_nx
);

   logic [E-1:0] sum;

   always_comb begin
      sum = a;
      unique case (1'b1)
         (!qr[0] &&  q_1): sum = a + mr;
         ( qr[0] && !q_1): sum = a - mr;
         default:          sum = a;
      endcase
   end

   // Shift {sum,qr,q_1} right by one, replicating the sign of sum.
   assign a_nx   = {sum[E-1], sum[E-1:1]};
   assign qr_nx  = {sum[0], qr[E-1:1]};
   assign q_1_nx = qr[0];

endmodule

// File: rtl/booth_seq_mul.sv
// Sequential radix-2 Booth multiplier, one iteration per clock.
// Ports: clk, rst, start/ready/busy/done handshake, mcand, mplier, product.
module booth_seq_mul
   import divmul_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int SIGNED = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   mcand,
   input  logic [WIDTH-1:0]   mplier,
   output logic               ready,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   // One guard bit lets unsigned operands run through the signed recoding.
   localparam int E    = WIDTH + 1;
   localparam int ITER = E;
   localparam int CW   = clog2(ITER + 1);

   state_t state, state_nx;

   logic [E-1:0]       a, qr, mr;
   logic               q_1;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] prod_q;

   logic [E-1:0] a_nx, qr_nx;
   logic         q_1_nx;
   logic [E-1:0] mcand_x, mplier_x;

   assign mcand_x  = {(SIGNED != 0) & mcand[WIDTH-1], mcand};
   assign mplier_x = {(SIGNED != 0) & mplier[WIDTH-1], mplier};

   booth_step #(.E(E)) u_step (
      .a      (a),
      .qr     (qr),
      .q_1    (q_1),
      .mr     (mr),
      .a_nx   (a_nx),
      .qr_nx  (qr_nx),
      .q_1_nx (q_1_nx)
   );

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (cnt == CW'(1)) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         a      <= '0;
         qr     <= '0;
         q_1    <= 1'b0;
         mr     <= '0;
         cnt    <= '0;
         prod_q <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && start) begin
            a   <= '0;
            qr  <= mplier_x;
            q_1 <= 1'b0;
            mr  <= mcand_x;
            cnt <= CW'(ITER);
         end else if (state == RUN) begin
            a   <= a_nx;
            qr  <= qr_nx;
            q_1 <= q_1_nx;
            cnt <= cnt - CW'(1);
            // Low 2*WIDTH bits of {A,Qr} after the final shift.
            if (cnt == CW'(1))
               prod_q <= {a_nx[WIDTH-2:0], qr_nx};
         end
      end
   end

   assign ready   = (state == IDLE);
   assign busy    = (state == RUN) || (state == DONE);
   assign done    = (state == DONE);
   assign product = prod_q;

endmodule

// File: tb/tb_booth_seq_mul.sv
// Bench for booth_seq_mul: unsigned and signed W=4 instances,
// directed cases plus random ops against an arithmetic model.
module tb_booth_seq_mul;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_u, start_u, rst_s, start_s;
   logic [3:0] mcand_u, mplier_u, mcand_s, mplier_s;
   logic       ready_u, busy_u, done_u, ready_s, busy_s, done_s;
   logic [7:0] product_u, product_s;

   booth_seq_mul #(.WIDTH(4), .SIGNED(0)) u_dut_u (
      .clk     (clk),
      .rst     (rst_u),
      .start   (start_u),
      .mcand   (mcand_u),
      .mplier  (mplier_u),
      .ready   (ready_u),
      .busy    (busy_u),
      .done    (done_u),
      .product (product_u)
   );

   booth_seq_mul #(.WIDTH(4), .SIGNED(1)) u_dut_s (
      .clk     (clk),
      .rst     (rst_s),
      .start   (start_s),
      .mcand   (mcand_s),
      .mplier  (mplier_s),
      .ready   (ready_s),
      .busy    (busy_s),
      .done    (done_s),
      .product (product_s)
   );

   logic       sel = 1'b0;
   logic       cur_ready, cur_busy, cur_done;
   logic [7:0] cur_product;

   assign cur_ready   = sel ? ready_s : ready_u;
   assign cur_busy    = sel ? busy_s : busy_u;
   assign cur_done    = sel ? done_s : done_u;
   assign cur_product = sel ? product_s : product_u;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag,
                        input logic [15:0] obs,
                        input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ref_prod(input logic s,
                                           input logic [3:0] x,
                                           input logic [3:0] y);
      int ix, iy;
      if (s) begin
         ix = $signed(x);
         iy = $signed(y);
      end else begin
         ix = int'(x);
         iy = int'(y);
      end
      return 8'(ix * iy);
   endfunction

   task automatic drive(input logic s, input logic [3:0] x,
                        input logic [3:0] y);
      if (sel) begin
         start_s = s; mcand_s = x; mplier_s = y;
      end else begin
         start_u = s; mcand_u = x; mplier_u = y;
      end
   endtask

   // Called at a negedge; returns at the negedge after the accept edge
   // with start still high.
   task automatic accept(input logic [3:0] x, input logic [3:0] y);
      int n;
      n = 0;
      while (!cur_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("ready_before_accept", 16'(cur_ready), 16'd1);
      drive(1'b1, x, y);
      @(posedge clk);
      @(negedge clk);
   endtask

   // Starts at the negedge right after the accept edge (j=0). Latency is
   // the index of the first edge at which done is sampled high.
   task automatic wait_done(output int lat, output logic rdy_seen);
      int j;
      j = 0;
      rdy_seen = 1'b0;
      while (!cur_done && j < 40) begin
         if (cur_ready) rdy_seen = 1'b1;
         @(negedge clk);
         j++;
      end
      lat = j + 1;
   endtask

   task automatic op(input logic [3:0] x, input logic [3:0] y,
                     input string tag);
      int         lat;
      logic       rdy_seen;
      logic [7:0] exp;
      exp = ref_prod(sel, x, y);
      accept(x, y);
      drive(1'b0, x, y);
      wait_done(lat, rdy_seen);
      check({tag, "_latency"}, 16'(lat), 16'd6);
      check({tag, "_product"}, 16'(cur_product), 16'(exp));
      check({tag, "_ready_in_run"}, 16'(rdy_seen | cur_ready), 16'd0);
      @(negedge clk);
      check({tag, "_ready_after"}, 16'({cur_ready, cur_done}), 16'b10);
      check({tag, "_product_held"}, 16'(cur_product), 16'(exp));
   endtask

   initial begin
      int         lat;
      logic       rdy_seen;
      logic       done_seen;
      logic [3:0] x, y;

      rst_u = 1'b1; rst_s = 1'b1;
      start_u = 1'b0; start_s = 1'b0;
      mcand_u = '0; mplier_u = '0; mcand_s = '0; mplier_s = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_u = 1'b0; rst_s = 1'b0;
      check("reset_u", 16'({ready_u, busy_u, done_u, product_u}),
            16'({3'b100, 8'h00}));
      check("reset_s", 16'({ready_s, busy_s, done_s, product_s}),
            16'({3'b100, 8'h00}));

      // Unsigned 15*15.
      sel = 1'b0;
      op(4'd15, 4'd15, "u_15x15");
      check("u_15x15_const", 16'(product_u), 16'h00E1);

      // Signed corner cases.
      sel = 1'b1;
      op(4'b1000, 4'b1000, "s_min_min");
      check("s_min_min_const", 16'(product_s), 16'h0040);
      op(4'hD, 4'd5, "s_m3x5");
      check("s_m3x5_const", 16'(product_s), 16'h00F1);
      op(4'd7, 4'hF, "s_7xm1");
      check("s_7xm1_const", 16'(product_s), 16'h00F9);

      // Exhaustive unsigned, back to back.
      sel = 1'b0;
      for (int i = 0; i < 16; i++)
         for (int k = 0; k < 16; k++)
            op(4'(i), 4'(k), "u_exh");

      // start held through RUN, operands changed mid-op.
      accept(4'd5, 4'd6);
      repeat (2) @(negedge clk);
      drive(1'b1, 4'd9, 4'd11);
      wait_done(lat, rdy_seen);
      check("hold_first_product", 16'(product_u), 16'd30);
      check("hold_not_ready_in_done", 16'(ready_u), 16'd0);
      @(negedge clk);
      check("hold_ready_after_done", 16'(ready_u), 16'd1);
      @(posedge clk);
      @(negedge clk);
      check("hold_second_accepted", 16'({ready_u, busy_u}), 16'b01);
      drive(1'b0, 4'd9, 4'd11);
      wait_done(lat, rdy_seen);
      check("hold_second_latency", 16'(lat), 16'd6);
      check("hold_second_product", 16'(product_u), 16'd99);
      @(negedge clk);

      // Reset in RUN with cnt==2 (three edges after accept).
      accept(4'd13, 4'd11);
      drive(1'b0, 4'd13, 4'd11);
      repeat (3) @(negedge clk);
      rst_u = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst_u = 1'b0;
      check("abort_state", 16'({ready_u, busy_u, done_u}), 16'b100);
      check("abort_product", 16'(product_u), 16'd0);
      done_seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         done_seen = done_seen | done_u;
      end
      check("abort_no_done", 16'(done_seen), 16'd0);
      op(4'd3, 4'd2, "after_abort");
      check("after_abort_const", 16'(product_u), 16'd6);

      // rst and start together: no accept.
      drive(1'b1, 4'd7, 4'd7);
      rst_u = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst_u = 1'b0;
      drive(1'b0, 4'd7, 4'd7);
      check("rst_start_busy", 16'(busy_u), 16'd0);
      check("rst_start_ready", 16'(ready_u), 16'd1);
      @(negedge clk);
      check("rst_start_idle", 16'({busy_u, done_u}), 16'b00);

      // Random operands on both instances.
      for (int n = 0; n < 40; n++) begin
         sel = 1'(n & 1);
         x = 4'($urandom_range(0, 15));
         y = 4'($urandom_range(0, 15));
         op(x, y, sel ? "rand_s" : "rand_u");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
